// File: rtl/complex_result_drain.sv
// complex_result_drain: buffers {status, imag, real} result pairs in a DEPTH-entry FIFO
// and serializes each pair as real word then imag word. Optional irq_o under COMPLEX_DRAIN_IRQ_EN.
module complex_result_drain #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [1:0][WIDTH-1:0]      result_i,
  input  logic [4:0]                 status_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [WIDTH-1:0]           out_data_o,
  output logic                       out_last_o,
  output logic [4:0]                 sticky_status_o,
  input  logic                       clr_status_i,
`ifdef COMPLEX_DRAIN_IRQ_EN
  output logic                       irq_o,
`endif
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       busy_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = 2*WIDTH + 5;

  typedef enum logic [1:0] {IDLE, REAL, IMAG} state_e;

  logic [EW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  state_e           state_q, state_d;
  logic [4:0]       sticky_q;
  logic [WIDTH-1:0] head_real, head_imag;
  logic             push, pop;

  // Ready depends on registered occupancy only; a same-cycle pop never frees a full FIFO.
  assign in_ready_o = (count_q != CW'(DEPTH));
  assign push       = in_valid_i && in_ready_o && !flush_i;
  assign pop        = (state_q == IMAG) && out_ready_i;

  assign head_real = mem_q[rd_ptr_q][WIDTH-1:0];
  assign head_imag = mem_q[rd_ptr_q][2*WIDTH-1:WIDTH];

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= {status_i, result_i[1], result_i[0]};
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= IDLE;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= IDLE;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  // Going straight from IMAG to REAL when more data is queued keeps the stream bubble-free.
  always_comb begin
    state_d     = state_q;
    out_valid_o = 1'b0;
    out_last_o  = 1'b0;
    out_data_o  = '0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) state_d = REAL;
      end
      REAL: begin
        out_valid_o = 1'b1;
        out_data_o  = head_real;
        if (out_ready_i) state_d = IMAG;
      end
      IMAG: begin
        out_valid_o = 1'b1;
        out_last_o  = 1'b1;
        out_data_o  = head_imag;
        if (out_ready_i) state_d = (count_d != '0) ? REAL : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A clear coinciding with an accept keeps the newly arriving status bits.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                     sticky_q <= '0;
    else if (clr_status_i && push)   sticky_q <= status_i;
    else if (clr_status_i)           sticky_q <= '0;
    else if (push)                   sticky_q <= sticky_q | status_i;
  end

`ifdef COMPLEX_DRAIN_IRQ_EN
  logic irq_q;

  // NV, DZ or OF on an accepted pair raises the interrupt; set beats clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                      irq_q <= 1'b0;
    else if (push && |status_i[4:2])  irq_q <= 1'b1;
    else if (clr_status_i)            irq_q <= 1'b0;
  end

  assign irq_o = irq_q;
`endif

  assign sticky_status_o = sticky_q;
  assign count_o         = count_q;
  assign busy_o          = (count_q != '0);

endmodule
